rs_enc_lane: RTL and testbench
==============================

# rs_enc_lane

Systematic Reed-Solomon encoder over GF(2^m) for the UART-to-VLC transmit path. Sits ahead of the optical modulator and feeds the lane that the RS_DE_LANE_QUATUS decoder terminates. Accepts framed message symbols on a streaming sink with sop/eop delimiting. Emits each message unchanged, followed by `check` parity symbols, on a matching streaming source with full backpressure.

## Interface
Parameters:
- check, 8, parity symbols appended per codeword (even, 2..16)
- m, 8, symbol width in bits
- irrpol, 285, field polynomial (x^8+x^4+x^3+x^2+1)
- genstart, 0, exponent of first generator root
- rootspace, 1, exponent step between generator roots

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- sink_val  in  1  input symbol valid
- sink_sop  in  1  first message symbol
- sink_eop  in  1  last message symbol
- sink_ena  out  1  encoder ready to accept
- rsin  in  m  message symbol
- source_val  out  1  output symbol valid
- source_sop  out  1  first codeword symbol
- source_eop  out  1  last check symbol
- source_ena  in  1  downstream ready
- rsout  out  m  codeword symbol
- frm_err  out  1  one-cycle pulse on framing error
- len_err  out  1  sticky overlength flag, cleared by next accepted sop

## Operation
- Transfer rule: a sink symbol is accepted on an edge where sink_val & sink_ena. A source symbol is consumed on an edge where source_val & source_ena.
- Generator: g(x)=prod_{i=0..check-1}(x - α^(genstart+i*rootspace)), monic. Coefficients g0..g(check-1) are computed at elaboration by constant functions from m/irrpol. No runtime table.
- Parity register p[0..check-1], m bits each. Per accepted data symbol d:
  - fb = d ^ p[check-1], or fb = d on sop, which implicitly clears p.
  - p[i] ← p[i-1] ^ fb·g_i.
  - p[0] ← fb·g0.
  - GF multiply is a combinational shift-and-reduce by irrpol.
- FSM states:
  - IDLE: waiting for sop.
  - DATA: passing message symbols.
  - CHECK: emitting parity symbols.
- Transitions:
  - IDLE→DATA on accepted sop without eop.
  - IDLE→CHECK on accepted sop&eop (1-symbol message).
  - DATA→CHECK on accepted eop.
  - CHECK→IDLE when the last parity symbol is loaded into the output register.
- CHECK emits p[check-1] first (highest-degree remainder coefficient). Then p shifts up with zero fill, with a check-1 down-counter.
- sink_ena = (source_ena | ~source_val) & (state != CHECK).
- Output register loads when source_ena | ~source_val and holds otherwise.
- Framing errors:
  - sink_val without sop in IDLE: symbol dropped, sink_ena still high, frm_err pulses.
  - sop in DATA: current codeword is abandoned without parity. source_eop is never emitted for it. The new sop starts a fresh codeword. frm_err pulses.
- Length: the message counter saturates at 2^m-1. When an accepted data symbol brings the count above 2^m-1-check, len_err sets. Encoding continues; the output is not a valid codeword.
- Data symbols pass through unmodified: rsout=rsin, source_sop=sink_sop.

## Timing
- Reset (asynchronous on reset=0): source_val=0, source_sop=0, source_eop=0, rsout=0, frm_err=0, len_err=0, p=0, state=IDLE. sink_ena reads 1 once reset is released.
- Latency: an accepted symbol appears on rsout/source_val on the next edge.
- With source_ena held 1, the first parity symbol appears the cycle after the eop data symbol is on the output. The `check` parity symbols follow back-to-back. source_eop is on the last one.
- Throughput: k+check cycles per codeword. A new sop is accepted in the cycle after the last parity symbol is loaded.
- source_ena=0 with source_val=1 freezes the output register, parity shifting, the counter, and sink_ena.
- Reset asserted mid-codeword discards everything. No partial parity is emitted after release.

## Test plan
- Message of 247 zeros (sop/eop), source_ena=1 → 255 symbols of 0x00, source_sop on symbol 0, source_eop on symbol 254, no gaps.
- Single symbol 0x01 with sop&eop → rsout 0x01 followed by g7..g0. The bench computes these from the same root set. Codeword evaluates to zero at α^0..α^7.
- 20 random 247-symbol messages looped through RS_DE_LANE_QUATUS with the channel bypassed → every block num_err_sym=0, decfail=0, payload matches.
- Same traffic with source_ena toggled pseudo-randomly at 50% → output symbol sequence identical to the unstalled run. No symbol is duplicated or lost.
- Framing: data without sop in IDLE → dropped, frm_err=1 for one cycle. 250-symbol message → len_err=1 from the 248th accepted symbol until the next sop.
- Reset pulled low at symbol 100 of a codeword, then released → all outputs 0 during reset. The next clean message encodes identically to a fresh-reset run.

Source files
------------

// File: rtl/rs_enc_lane.sv
// Systematic Reed-Solomon encoder lane over GF(2^m).
// Message symbols stream in on the sink (sop/eop framed) and pass straight through. After eop,
// `check` parity symbols follow, highest-degree remainder coefficient first.
// Ports:
//   clk, reset (async, active-low)
//   sink_val/sink_sop/sink_eop/rsin : message sink, sink_ena is the ready back to the sender
//   source_val/source_sop/source_eop/rsout : codeword source, source_ena is downstream ready
//   frm_err : one-cycle pulse on a framing error
//   len_err : sticky overlength flag, cleared by the next accepted sop
module rs_enc_lane #(
  parameter int unsigned check     = 8,
  parameter int unsigned m         = 8,
  parameter int unsigned irrpol    = 285,
  parameter int unsigned genstart  = 0,
  parameter int unsigned rootspace = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sink_val,
  input  logic         sink_sop,
  input  logic         sink_eop,
  output logic         sink_ena,
  input  logic [m-1:0] rsin,
  output logic         source_val,
  output logic         source_sop,
  output logic         source_eop,
  input  logic         source_ena,
  output logic [m-1:0] rsout,
  output logic         frm_err,
  output logic         len_err
);

  localparam int unsigned    CntW     = (check > 1) ? $clog2(check) : 1;
  localparam int unsigned    FieldN   = (32'd1 << m) - 32'd1;
  localparam logic [m-1:0]   PolyLow  = m'(irrpol);
  localparam logic [m-1:0]   LenLimit = m'(FieldN - check);

  // Shift-and-reduce multiply; also used at elaboration to build the generator.
  function automatic logic [m-1:0] gf_mul(input logic [m-1:0] a, input logic [m-1:0] b);
    logic [m-1:0] r;
    logic [m-1:0] x;
    r = '0;
    x = a;
    for (int i = 0; i < int'(m); i++) begin
      if (b[i]) r = r ^ x;
      x = x[m-1] ? ((x << 1) ^ PolyLow) : (x << 1);
    end
    return r;
  endfunction

  function automatic logic [m-1:0] alpha_pow(input int unsigned e);
    logic [m-1:0] r;
    r = m'(1);
    for (int unsigned i = 0; i < e; i++) r = gf_mul(r, m'(2));
    return r;
  endfunction

  // Coefficients g0..g(check-1) of the monic generator; the implicit x^check term is dropped.
  function automatic logic [check*m-1:0] gen_poly();
    logic [(check+1)*m-1:0] g;
    logic [m-1:0]           root;
    logic [m-1:0]           t;
    g = '0;
    g[m-1:0] = m'(1);
    for (int unsigned i = 0; i < check; i++) begin
      root = alpha_pow((genstart + i * rootspace) % FieldN);
      for (int j = int'(check); j >= 0; j--) begin
        t = gf_mul(root, g[j*m +: m]);
        if (j > 0) t = t ^ g[(j-1)*m +: m];
        g[j*m +: m] = t;
      end
    end
    return g[check*m-1:0];
  endfunction

  localparam logic [check*m-1:0] GenCoef = gen_poly();

  typedef enum logic [1:0] {StIdle, StData, StCheck} state_e;

  state_e                    state_q, state_d;
  logic [check-1:0][m-1:0]   p_q, p_d, p_upd;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [m-1:0]              len_q, len_d, len_new;
  logic                      len_err_q, len_err_d;
  logic                      frm_err_q, frm_err_d;
  logic                      val_q, val_d, sop_q, sop_d, eop_q, eop_d;
  logic [m-1:0]              data_q, data_d;
  logic                      adv, acc, take;
  logic [m-1:0]              fb;

  // Output register may advance when empty or being drained this cycle.
  assign adv  = source_ena | ~val_q;
  assign acc  = sink_val & sink_ena;
  // Symbols that become part of a codeword; a stray non-sop symbol in idle is dropped.
  assign take = acc & (sink_sop | (state_q == StData));
  // A sop restarts the division, which is the same as starting from a cleared register.
  assign fb   = sink_sop ? rsin : (rsin ^ p_q[check-1]);

  always_comb begin
    p_upd    = '0;
    p_upd[0] = gf_mul(fb, GenCoef[0 +: m]);
    for (int i = 1; i < int'(check); i++) begin
      p_upd[i] = gf_mul(fb, GenCoef[i*m +: m]) ^ (sink_sop ? '0 : p_q[i-1]);
    end
  end

  assign len_new = sink_sop ? m'(1) : ((len_q == '1) ? len_q : len_q + 1'b1);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StData: if (take) state_d = sink_eop ? StCheck : StData;
      StCheck:        if (adv && (cnt_q == '0)) state_d = StIdle;
      default:        state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    p_d       = p_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    len_err_d = len_err_q;
    val_d     = val_q;
    sop_d     = sop_q;
    eop_d     = eop_q;
    data_d    = data_q;
    frm_err_d = acc & (((state_q == StIdle) & ~sink_sop) | ((state_q == StData) & sink_sop));
    if (adv) begin
      if (state_q == StCheck) begin
        data_d = p_q[check-1];
        val_d  = 1'b1;
        sop_d  = 1'b0;
        eop_d  = (cnt_q == '0);
        p_d    = p_q << m;
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end else begin
        val_d = 1'b0;
        sop_d = 1'b0;
        eop_d = 1'b0;
        if (take) begin
          data_d    = rsin;
          val_d     = 1'b1;
          sop_d     = sink_sop;
          p_d       = p_upd;
          len_d     = len_new;
          len_err_d = (len_err_q & ~sink_sop) | (len_new > LenLimit);
          if (sink_eop) cnt_d = CntW'(check - 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_q       <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      len_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      val_q     <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      len_err_q <= len_err_d;
      frm_err_q <= frm_err_d;
      val_q     <= val_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      data_q    <= data_d;
    end
  end

  // Outputs
  always_comb begin
    sink_ena   = adv & (state_q != StCheck);
    source_val = val_q;
    source_sop = sop_q;
    source_eop = eop_q;
    rsout      = data_q;
    frm_err    = frm_err_q;
    len_err    = len_err_q;
  end

endmodule

// File: tb/tb_rs_enc_lane.sv
// Self-checking bench for rs_enc_lane (check=8, m=8, field 0x11d, roots alpha^0..alpha^7).
// Reference: log/exp-table field arithmetic and polynomial long division.
module tb_rs_enc_lane;
  localparam int CHK = 8;
  localparam int NN  = 255;
  localparam int KK  = NN - CHK;
  localparam int NW  = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sink_val = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0;
  logic [7:0] rsin = 8'h00;
  logic       source_ena = 1'b1;
  logic       sink_ena, source_val, source_sop, source_eop, frm_err, len_err;
  logic [7:0] rsout;

  rs_enc_lane #(.check(8), .m(8), .irrpol(285), .genstart(0), .rootspace(1)) dut (
    .clk(clk), .reset(reset), .sink_val(sink_val), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_ena(sink_ena), .rsin(rsin), .source_val(source_val), .source_sop(source_sop),
    .source_eop(source_eop), .source_ena(source_ena), .rsout(rsout), .frm_err(frm_err),
    .len_err(len_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0, frm_cnt = 0;
  bit stall_en = 1'b0;
  int gexp[0:509];
  int glog[0:255];
  int gen[0:CHK];
  logic [7:0] tx_msg[$], exp_cw[$], cap_data[$], ref_stream[$];
  bit cap_sop[$], cap_eop[$];
  int cap_cyc[$], len_trace[$];
  logic [7:0] saved_msgs[NW][KK];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    source_ena = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  always @(negedge clk) begin
    if (reset) begin
      if (source_val && source_ena) begin
        cap_data.push_back(rsout);
        cap_sop.push_back(source_sop);
        cap_eop.push_back(source_eop);
        cap_cyc.push_back(cyc);
      end
      if (frm_err) frm_cnt++;
    end
  end

  function automatic int gmul(int a, int b);
    if (a == 0 || b == 0) return 0;
    return gexp[glog[a] + glog[b]];
  endfunction

  task automatic gf_init();
    int x = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = x; gexp[i+255] = x; glog[x] = i;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 285;
    end
    for (int j = 0; j <= CHK; j++) gen[j] = (j == 0) ? 1 : 0;
    for (int i = 0; i < CHK; i++)
      for (int j = CHK; j >= 0; j--) gen[j] = gmul(gen[j], gexp[i]) ^ ((j > 0) ? gen[j-1] : 0);
  endtask

  // Codeword = message followed by remainder of msg(x)*x^CHK divided by g(x).
  task automatic build_expected();
    int c[$];
    int k = tx_msg.size();
    foreach (tx_msg[i]) c.push_back(int'(tx_msg[i]));
    repeat (CHK) c.push_back(0);
    for (int i = 0; i < k; i++) begin
      int coef = c[i];
      if (coef != 0) for (int j = 1; j <= CHK; j++) c[i+j] = c[i+j] ^ gmul(coef, gen[CHK-j]);
    end
    exp_cw = {};
    for (int i = 0; i < k; i++) exp_cw.push_back(tx_msg[i]);
    for (int i = 0; i < CHK; i++) exp_cw.push_back(8'(c[k+i]));
  endtask

  function automatic int syn(int j);
    int s = 0;
    foreach (cap_data[i]) s = gmul(s, gexp[j]) ^ int'(cap_data[i]);
    return s;
  endfunction

  function automatic int cw_mismatch();
    int n = 0;
    if (cap_data.size() != exp_cw.size()) n++;
    for (int i = 0; i < exp_cw.size() && i < cap_data.size(); i++)
      if (cap_data[i] !== exp_cw[i]) n++;
    return n;
  endfunction

  task automatic clear_cap();
    cap_data = {}; cap_sop = {}; cap_eop = {}; cap_cyc = {};
  endtask

  // Drives the first n_stop symbols of tx_msg; eop only if the last symbol is reached.
  task automatic send_msg(input int n_stop);
    int n = (n_stop < tx_msg.size()) ? n_stop : tx_msg.size();
    len_trace = {};
    for (int i = 0; i < n; i++) begin
      bit ok = 1'b0;
      int budget = 0;
      sink_val = 1'b1; sink_sop = (i == 0); sink_eop = (i == tx_msg.size() - 1); rsin = tx_msg[i];
      while (!ok) begin
        @(negedge clk); ok = sink_ena;
        @(posedge clk); #1;
        budget++;
        if (!ok && budget > 3000) begin
          checks++; failures++;
          $display("FAIL send_timeout symbol=%0d accepted=0 required=1", i);
          sink_val = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
          return;
        end
      end
      len_trace.push_back(int'(len_err));
    end
    sink_val = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
  endtask

  task automatic wait_out(input int n, input string tag);
    int b = 0;
    while (cap_data.size() < n && b < 5000) begin @(posedge clk); b++; end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cap_data.size() != n) begin
      failures++;
      $display("FAIL %s_count got=%0d required=%0d", tag, cap_data.size(), n);
    end
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    #2 reset = 1'b0;
    @(negedge clk);
    obs = {source_val, source_sop, source_eop, frm_err, len_err, rsout};
    checks++;
    if (obs !== 13'd0) begin failures++; $display("FAIL reset_outputs got=%h required=0", obs); end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (sink_ena !== 1'b1) begin failures++; $display("FAIL reset_sink_ena got=%b required=1", sink_ena); end
    obs = {source_val, source_sop, source_eop, frm_err, len_err, rsout};
    checks++;
    if (obs !== 13'd0) begin failures++; $display("FAIL post_reset_outputs got=%h required=0", obs); end
    @(posedge clk); #1;
  endtask

  task automatic test_zeros();
    int nz = 0, ns = 0, ne = 0;
    tx_msg = {};
    repeat (KK) tx_msg.push_back(8'h00);
    build_expected(); clear_cap();
    send_msg(KK); wait_out(NN, "zeros");
    foreach (cap_data[i]) begin
      if (cap_data[i] !== 8'h00) nz++;
      if (cap_sop[i] !== (i == 0)) ns++;
      if (cap_eop[i] !== (i == NN - 1)) ne++;
    end
    checks++; if (nz != 0) begin failures++; $display("FAIL zeros_data nonzero=%0d required=0", nz); end
    checks++; if (ns != 0) begin failures++; $display("FAIL zeros_sop badpos=%0d required=0", ns); end
    checks++; if (ne != 0) begin failures++; $display("FAIL zeros_eop badpos=%0d required=0", ne); end
    checks++;
    if (cap_cyc.size() != NN || cap_cyc[NN-1] - cap_cyc[0] != NN - 1) begin
      failures++; $display("FAIL zeros_gapless span=%0d required=%0d", cap_cyc[$] - cap_cyc[0], NN - 1);
    end
  endtask

  task automatic test_single();
    tx_msg = {8'h01};
    build_expected(); clear_cap();
    send_msg(1); wait_out(1 + CHK, "single");
    checks++;
    if (cap_data[0] !== 8'h01) begin failures++; $display("FAIL single_data got=%h required=01", cap_data[0]); end
    for (int i = 0; i < CHK; i++) begin
      checks++;
      if (int'(cap_data[1+i]) != gen[CHK-1-i]) begin
        failures++; $display("FAIL single_g%0d got=%h required=%h", CHK-1-i, cap_data[1+i], gen[CHK-1-i]);
      end
    end
    for (int j = 0; j < CHK; j++) begin
      checks++;
      if (syn(j) != 0) begin failures++; $display("FAIL single_syndrome%0d got=%h required=0", j, syn(j)); end
    end
  endtask

  task automatic test_random(input bit stalled);
    for (int w = 0; w < NW; w++) begin
      int mm, bad;
      tx_msg = {};
      for (int i = 0; i < KK; i++) begin
        if (!stalled) saved_msgs[w][i] = 8'($urandom);
        tx_msg.push_back(saved_msgs[w][i]);
      end
      build_expected(); clear_cap();
      stall_en = stalled;
      send_msg(KK); wait_out(NN, stalled ? "stall" : "random");
      stall_en = 1'b0;
      mm = cw_mismatch();
      checks++;
      if (mm != 0) begin failures++; $display("FAIL cw_word%0d_stall%0d mismatches=%0d required=0", w, stalled, mm); end
      bad = 0;
      if (!stalled) begin
        foreach (cap_data[i]) ref_stream.push_back(cap_data[i]);
        for (int j = 0; j < CHK; j++) if (syn(j) != 0) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL syndrome_word%0d nonzero=%0d required=0", w, bad); end
      end else begin
        foreach (cap_data[i]) if (w * NN + i >= ref_stream.size() || cap_data[i] !== ref_stream[w*NN+i]) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL stall_vs_unstalled word%0d diffs=%0d required=0", w, bad); end
      end
    end
  endtask

  task automatic test_frame_idle();
    clear_cap(); frm_cnt = 0;
    sink_val = 1'b1; sink_sop = 1'b0; sink_eop = 1'b0; rsin = 8'h5a;
    @(negedge clk);
    checks++;
    if (sink_ena !== 1'b1) begin failures++; $display("FAIL idle_stray_ena got=%b required=1", sink_ena); end
    @(posedge clk); #1 sink_val = 1'b0;
    @(negedge clk);
    checks++;
    if (frm_err !== 1'b1) begin failures++; $display("FAIL idle_frm_err got=%b required=1", frm_err); end
    @(negedge clk);
    checks++;
    if (frm_err !== 1'b0) begin failures++; $display("FAIL idle_frm_err_pulse got=%b required=0", frm_err); end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (cap_data.size() != 0 || frm_cnt != 1) begin
      failures++; $display("FAIL idle_dropped outputs=%0d pulses=%0d required=0,1", cap_data.size(), frm_cnt);
    end
  endtask

  task automatic test_sop_in_data();
    logic [7:0] part[$];
    int bad = 0;
    clear_cap(); frm_cnt = 0;
    tx_msg = {};
    repeat (10) tx_msg.push_back(8'($urandom));
    for (int i = 0; i < 5; i++) part.push_back(tx_msg[i]);
    send_msg(5);
    tx_msg = {};
    repeat (12) tx_msg.push_back(8'($urandom));
    build_expected();
    exp_cw = {part, exp_cw};
    send_msg(12); wait_out(5 + 12 + CHK, "abandon");
    checks++;
    if (cw_mismatch() != 0) begin failures++; $display("FAIL abandon_data mismatches=%0d required=0", cw_mismatch()); end
    foreach (cap_data[i]) begin
      if (cap_sop[i] !== (i == 0 || i == 5)) bad++;
      if (cap_eop[i] !== (i == cap_data.size() - 1)) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL abandon_flags badpos=%0d required=0", bad); end
    checks++;
    if (frm_cnt != 1) begin failures++; $display("FAIL abandon_frm_err pulses=%0d required=1", frm_cnt); end
  endtask

  task automatic test_len();
    tx_msg = {};
    repeat (250) tx_msg.push_back(8'($urandom));
    build_expected(); clear_cap();
    send_msg(250); wait_out(250 + CHK, "len");
    checks++;
    if (len_trace[246] != 0 || len_trace[247] != 1 || len_trace[249] != 1) begin
      failures++;
      $display("FAIL len_err_onset got=%0d%0d%0d required=011", len_trace[246], len_trace[247], len_trace[249]);
    end
    checks++;
    if (cw_mismatch() != 0) begin failures++; $display("FAIL len_data mismatches=%0d required=0", cw_mismatch()); end
    checks++;
    if (len_err !== 1'b1) begin failures++; $display("FAIL len_err_sticky got=%b required=1", len_err); end
    tx_msg = {};
    repeat (3) tx_msg.push_back(8'($urandom));
    build_expected(); clear_cap();
    send_msg(3); wait_out(3 + CHK, "len_next");
    checks++;
    if (len_trace[0] != 0 || len_err !== 1'b0) begin
      failures++; $display("FAIL len_err_clear got=%0d,%b required=0,0", len_trace[0], len_err);
    end
    checks++;
    if (cw_mismatch() != 0) begin failures++; $display("FAIL len_next_data mismatches=%0d required=0", cw_mismatch()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e1[$];
    int bad = 0;
    clear_cap();
    tx_msg = {};
    repeat (5) tx_msg.push_back(8'($urandom));
    build_expected(); e1 = exp_cw;
    send_msg(5);
    tx_msg = {};
    repeat (9) tx_msg.push_back(8'($urandom));
    build_expected(); exp_cw = {e1, exp_cw};
    send_msg(9); wait_out(5 + 9 + 2 * CHK, "b2b");
    checks++;
    if (cw_mismatch() != 0) begin failures++; $display("FAIL b2b_data mismatches=%0d required=0", cw_mismatch()); end
    foreach (cap_data[i]) begin
      if (cap_sop[i] !== (i == 0 || i == 13)) bad++;
      if (cap_eop[i] !== (i == 12 || i == 29)) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL b2b_flags badpos=%0d required=0", bad); end
    checks++;
    if (cap_cyc[$] - cap_cyc[0] != 29) begin
      failures++; $display("FAIL b2b_span got=%0d required=29", cap_cyc[$] - cap_cyc[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] obs;
    tx_msg = {};
    repeat (KK) tx_msg.push_back(8'($urandom));
    send_msg(100);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs = {source_val, source_sop, source_eop, frm_err, len_err, rsout};
      checks++;
      if (obs !== 13'd0) begin failures++; $display("FAIL midreset_outputs%0d got=%h required=0", i, obs); end
    end
    @(posedge clk); #1 reset = 1'b1;
    clear_cap();
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (cap_data.size() != 0) begin failures++; $display("FAIL midreset_leftover got=%0d required=0", cap_data.size()); end
    tx_msg = {};
    repeat (30) tx_msg.push_back(8'($urandom));
    build_expected(); clear_cap();
    send_msg(30); wait_out(30 + CHK, "midreset_next");
    checks++;
    if (cw_mismatch() != 0) begin failures++; $display("FAIL midreset_next mismatches=%0d required=0", cw_mismatch()); end
  endtask

  initial begin
    gf_init();
    test_reset();
    test_zeros();
    test_single();
    test_random(1'b0);
    test_random(1'b1);
    test_frame_idle();
    test_sop_in_data();
    test_len();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
